// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a MEM_LAT-deep in-flight tracker feeding a decode FIFO.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a returning word straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 2,
  parameter logic [61:0] RESET_PC = 62'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [61:0] redirect_pc,
  output logic [61:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic [61:0] out_pc
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW       = $clog2(DEPTH + MEM_LAT + 1);
  localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

  logic [61:0]        r_fetch_pc;
  logic [MEM_LAT-1:0] r_trk_vld;
  logic [61:0]        r_trk_pc [MEM_LAT];
  logic [31:0]        r_ins    [DEPTH];
  logic [61:0]        r_pc     [DEPTH];
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW:0]        r_occ;

  logic [CW-1:0]      w_inflight;
  logic               w_issue;
  logic               w_ret;
  logic               w_fifo_nempty;
  logic               w_bypass;
  logic               w_pop;
  logic               w_push;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_trk_vld[i]);
    end
  end

  // A pop this cycle is deliberately not credited, so occ + inflight never exceeds DEPTH.
  assign w_issue       = !redirect_valid && ((CW'(r_occ) + w_inflight) < CW'(DEPTH));
  assign w_ret         = r_trk_vld[MEM_LAT-1];
  assign w_fifo_nempty = (r_occ != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_ret && !w_fifo_nempty && !redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop     = w_fifo_nempty && out_ready && !redirect_valid;
  assign w_push    = w_ret && !redirect_valid && !(w_bypass && out_ready);
  assign mem_raddr = r_fetch_pc;
  assign out_valid = w_fifo_nempty || w_bypass;

  always_comb begin
    out_ins = '0;
    out_pc  = '0;
    if (w_fifo_nempty) begin
      out_ins = r_ins[r_rd_ptr];
      out_pc  = r_pc[r_rd_ptr];
    end else if (w_bypass) begin
      out_ins = mem_rdata;
      out_pc  = r_trk_pc[MEM_LAT-1];
    end
  end

  // Control state: fetch PC, tracker valids, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_trk_vld  <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_trk_vld  <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_occ      <= '0;
    end else begin
      r_trk_vld <= MEM_LAT'({r_trk_vld, w_issue});
      if (w_issue) r_fetch_pc <= r_fetch_pc + 62'd1;
      if (w_pop)   r_rd_ptr   <= r_rd_ptr + AW'(1);
      if (w_push)  r_wr_ptr   <= r_wr_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW + 1)'(1);
        2'b01:   r_occ <= r_occ - (AW + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Data path: tracker PCs and FIFO payload carry no reset; valids above qualify them.
  always_ff @(posedge clk) begin
    r_trk_pc[0] <= r_fetch_pc;
    for (int i = 1; i < MEM_LAT; i++) begin
      r_trk_pc[i] <= r_trk_pc[i-1];
    end
    if (w_push) begin
      r_ins[r_wr_ptr] <= mem_rdata;
      r_pc[r_wr_ptr]  <= r_trk_pc[MEM_LAT-1];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && w_push && !w_pop) begin
      assert (r_occ != OCC_FULL);
    end
  end
`endif

endmodule
